uart_tx_fifo: RTL
=================

// Module: uart_tx_fifo
// PURPOSE
//  Parametrised UART transmitter: buffered byte stream in, serial line out.
//  Internal baud divider, configurable data width, parity and stop bits.
//  Includes a TX FIFO with a level valid/ready handshake.
//  Sits between the host/command path and the board TX pin.
//  Streams frames back-to-back with no idle gap while data is queued.
// PARAMETERS
//  CLKS_PER_BIT  868  CLK cycles per serial bit; >=2
//  DATA_BITS     8    payload bits per frame; 5..9
//  PARITY        0    0=none, 1=odd, 2=even
//  STOP_BITS     1    1 or 2
//  FIFO_DEPTH    16   TX FIFO entries; power of 2, >=2
// PORTS
//  CLK         in   1                      clock
//  rst         in   1                      synchronous, active-high reset
//  s_data      in   DATA_BITS              byte to queue
//  s_valid     in   1                      s_data valid (level)
//  s_ready     out  1                      FIFO can accept
//  TX          out  1                      serial line, idle high
//  busy        out  1                      frame in flight or FIFO non-empty
//  fifo_count  out  $clog2(FIFO_DEPTH)+1   queued entries
// BEHAVIOUR
//  Reset:
//   - Values: TX=1, busy=0, fifo_count=0, s_ready=1; FSM=IDLE; baud counter=0.
//   - Reset mid-frame aborts the frame and flushes the FIFO.
//   - TX is high in the first cycle after reset.
//  Handshake:
//   - A word is written when s_valid && s_ready at a rising edge.
//   - s_valid is level-sensitive; no edge detect. Holding s_valid high writes every cycle.
//   - s_ready = (fifo_count != FIFO_DEPTH), combinational from the count.
//   - A write to an empty FIFO is poppable from the next cycle, never the same cycle.
//   - Simultaneous push and pop leaves fifo_count unchanged.
//  FSM states: IDLE, START, DATA, PAR, STOP.
//   - IDLE: TX=1. If fifo_count>0, pop the head into a shift register, enter START.
//   - START: TX=0 for CLKS_PER_BIT cycles.
//   - DATA: DATA_BITS bits, LSB first, each CLKS_PER_BIT cycles.
//   - PAR: entered only if PARITY!=0; one bit.
//     - even: ^data (total number of ones even).
//     - odd: ~^data.
//   - STOP: TX=1 for STOP_BITS*CLKS_PER_BIT cycles.
//   - End of STOP: if FIFO non-empty, pop in the same cycle and go to START; else go to IDLE.
//  Baud counter:
//   - Counts 0..CLKS_PER_BIT-1 and restarts on every state entry.
//   - A bit ends when the counter reaches CLKS_PER_BIT-1.
//  Timing:
//   - TX is registered. Pop at edge t gives TX=0 from t+1.
//   - Frame length = (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles exactly.
//   - Back-to-back frames: the next start bit immediately follows the last stop cycle.
//  busy = (state!=IDLE) || (fifo_count!=0).
//  fifo_count update: +1 on write only, -1 on pop only; never wraps past 0 or FIFO_DEPTH.
//  Pointers: $clog2(FIFO_DEPTH) bits and wrap naturally.
// TESTING
//  1. CLKS_PER_BIT=4, 8N1, push 0xA5 once
//     -> TX sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles, 40 cycles total.
//     -> busy falls the cycle after the stop bit ends.
//  2. DATA_BITS=7, even parity, 0x41 -> parity bit 0.
//     Same with odd parity -> parity bit 1. Frame = 10 bits.
//  3. Push 0x00 then 0xFF back-to-back
//     -> second start bit begins exactly 10*CLKS_PER_BIT cycles after the first.
//     -> no idle high bit between frames.
//  4. FIFO_DEPTH=16, hold s_valid high for 20 cycles, CLKS_PER_BIT large
//     -> 17 writes accepted (one popped).
//     -> s_ready low with fifo_count=16 from then on.
//     -> all 17 bytes later appear on TX in order.
//  5. STOP_BITS=2 -> TX high for 2*CLKS_PER_BIT cycles between two queued frames.
//  6. Assert rst mid DATA state with 3 bytes queued
//     -> next cycle TX=1, fifo_count=0, busy=0.
//     -> no further frames are sent.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a TX FIFO: bytes queued over s_valid/s_ready
// are sent LSB first on TX with optional parity and 1 or 2 stop bits.
//
// Ports:
//   CLK, rst    clock; synchronous active-high reset
//   s_data      word to queue (DATA_BITS wide)
//   s_valid     level-sensitive write request
//   s_ready     FIFO not full
//   TX          registered serial line, idle high
//   busy        frame in flight or FIFO not empty
//   fifo_count  number of queued words
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          CLK,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          TX,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [AW:0]   FULL     = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT-1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS-1);
  localparam logic          STP_LAST = 1'(STOP_BITS-1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic                 push;
  logic                 pop;

  state_t               state;
  state_t               state_d;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_d;
  logic [BW-1:0]        bit_idx;
  logic [BW-1:0]        bit_d;
  logic                 stp_idx;
  logic                 stp_d;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] sh_d;
  logic                 par_bit;
  logic                 par_d;
  logic                 tx_q;
  logic                 tx_d;
  logic                 bit_end;
  logic [DATA_BITS-1:0] head;
  logic                 head_par;

  assign s_ready = (fifo_count != FULL);
  assign push    = s_valid && s_ready;
  assign busy    = (state != IDLE) || (fifo_count != '0);
  assign TX      = tx_q;

  assign head     = mem[rd_ptr];
  assign head_par = (PARITY == 1) ? ~^head : ^head;
  assign bit_end  = (cnt == CNT_LAST);

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= s_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      stp_idx <= 1'b0;
      shreg   <= '0;
      par_bit <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bit_idx <= bit_d;
      stp_idx <= stp_d;
      shreg   <= sh_d;
      par_bit <= par_d;
      tx_q    <= tx_d;
    end
  end

  // The baud counter restarts on every state entry; a popped word is
  // latched with its parity so the shifter can consume the data bits.
  always_comb begin
    state_d = state;
    cnt_d   = cnt + CW'(1);
    bit_d   = bit_idx;
    stp_d   = stp_idx;
    sh_d    = shreg;
    par_d   = par_bit;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_d = '0;
        if (fifo_count != '0) begin
          pop     = 1'b1;
          state_d = START;
          sh_d    = head;
          par_d   = head_par;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          sh_d  = shreg >> 1;
          if (bit_idx == BIT_LAST) begin
            state_d = (PARITY != 0) ? PAR : STOP;
            stp_d   = 1'b0;
          end else begin
            bit_d = bit_idx + BW'(1);
          end
        end
      end
      PAR: begin
        if (bit_end) begin
          state_d = STOP;
          cnt_d   = '0;
          stp_d   = 1'b0;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (stp_idx == STP_LAST) begin
            // Back-to-back: pop on the last stop cycle, no idle bit.
            if (fifo_count != '0) begin
              pop     = 1'b1;
              state_d = START;
              sh_d    = head;
              par_d   = head_par;
            end else begin
              state_d = IDLE;
            end
          end else begin
            stp_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // TX is registered from the next-state view so it changes with state.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = sh_d[0];
      PAR:     tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

endmodule
